pw_bit_rx: RTL and testbench
============================

Name: pw_bit_rx

Overview:
Receiver and decoder for the single-wire pulse-width bit encoding driven on one txd lane of the pulse-width bit transmitter.
- Each bit is one high pulse followed by a low gap; a long pulse is 1, a short pulse is 0.
- Pulses are measured in aclk cycles, shifted MSB first into a DATA_WIDTH word, and delivered on an AXI-Stream-style master port.
- Framing, glitch and overflow status are exposed as sticky flags.
- One instance decodes one lane; the top level instantiates one per lane.

Parameters:
DATA_WIDTH, 32, bits per decoded word; range 1..64.
CNT_WIDTH, 16, width of the pulse and gap counters and of every cfg_* timing input.
SYNC_STAGES, 2, flops in the rxd synchroniser; minimum 2.

Ports:
aclk  in  1  clock.
aresetn  in  1  reset; asynchronous assert, active-low.
rxd  in  1  asynchronous pulse-width line.
cfg_enable  in  1  decoder enable; 0 holds the FSM in IDLE and clears the partial word.
cfg_min_high  in  CNT_WIDTH  high pulses shorter than this are glitches.
cfg_thresh  in  CNT_WIDTH  high count >= thresh decodes as 1, otherwise 0.
cfg_max_high  in  CNT_WIDTH  high count > this is a stuck-high error.
cfg_idle  in  CNT_WIDTH  low count reaching this ends a frame.
m_axis_tdata  out  DATA_WIDTH  decoded word.
m_axis_tvalid  out  1  word valid.
m_axis_tready  in  1  downstream accept.
stat_frame_err  out  1  sticky: partial word at idle, or stuck high.
stat_glitch  out  1  sticky: pulse shorter than cfg_min_high.
stat_overflow  out  1  sticky: completed word dropped because the output register was full.
stat_clear  in  1  single-cycle pulse; clears all stat_* flags.

Behaviour:
- Reset values: all outputs 0. Internally: FSM in IDLE, counters 0, bit_cnt 0, shift register 0, synchroniser flops 0.
- cfg_* inputs are quasi-static. Changing them mid-frame is legal but the current pulse's result is undefined.
- rxd passes through SYNC_STAGES flops to give rxd_s; a registered copy rxd_d provides rise = rxd_s & ~rxd_d and fall = ~rxd_s & rxd_d.
- FSM states: IDLE, HIGH, LOW, STUCK.
- IDLE:
  - Leaves only after rxd_s has been low for cfg_idle consecutive cycles (armed flag); this prevents decoding mid-frame after reset or enable.
  - On rise while armed -> HIGH, with high_cnt = 1.
- HIGH:
  - high_cnt increments each cycle rxd_s = 1, saturating at all-ones.
  - If high_cnt > cfg_max_high: set stat_frame_err, discard the partial word, -> STUCK.
  - On fall with high_cnt < cfg_min_high: set stat_glitch, word unchanged, -> LOW.
  - On fall otherwise: shift in bit (high_cnt >= cfg_thresh), bit_cnt++, low_cnt = 0, -> LOW.
- LOW:
  - low_cnt increments each cycle, saturating.
  - On rise -> HIGH, with high_cnt = 1 and low_cnt cleared.
  - When low_cnt reaches cfg_idle: if bit_cnt != 0, set stat_frame_err and discard the partial word. Then -> IDLE with armed = 1.
- STUCK: waits until rxd_s has been low cfg_idle cycles, then -> IDLE with armed = 1.
- Word completion:
  - On the shift that makes bit_cnt == DATA_WIDTH, the word is loaded into the output register and bit_cnt returns to 0.
  - Consecutive words need no idle gap.
- Output register is single entry:
  - tvalid rises the cycle after the completing shift.
  - tdata is stable while tvalid = 1 and tready = 0.
  - tvalid & tready clears it.
  - If a word completes while tvalid = 1 and tready = 0: drop the new word and set stat_overflow.
  - If it completes in the same cycle as a handshake: the new word loads and tvalid stays 1.
- Latency: a final rxd falling edge at the pin gives tvalid = 1 at SYNC_STAGES + 2 aclk edges.
- stat_clear and a set event in the same cycle: the set wins.
- cfg_enable = 0: immediately -> IDLE, armed = 0, bit_cnt = 0. The output register and stat_* flags are untouched.
- aresetn low at any time (mid-pulse, mid-word, tvalid held): everything returns to reset values asynchronously. After release, IDLE must re-arm before any decoding.

Decomposition:
- Package pw_bit_pkg holds:
  - the FSM state enum (IDLE, HIGH, LOW, STUCK);
  - default timing constants shared with the transmitter: T0_HIGH = 15, T1_HIGH = 30, BIT_PERIOD = 60, DEFAULT_THRESH = 23, DEFAULT_IDLE = 120.
- One sub-module, pw_bit_sync: an SYNC_STAGES-deep synchroniser plus edge detector, outputting rxd_s, rise and fall.

Test Plan:
- Reset and arm: idle 120 cycles, then send 0xA5A5A5A5 with T0 = 15, T1 = 30, period 60, thresh 23, tready = 1 -> exactly one tvalid pulse, tdata = 0xA5A5A5A5, all stat flags 0.
- Back-pressure: two back-to-back words 0x00000001 and 0xFFFFFFFF with tready held 0 -> tdata holds 0x00000001, stat_overflow = 1. Raising tready -> one accept and 0xFFFFFFFF is never presented.
- Glitch: a 2-cycle high pulse between bits with min_high = 5 -> stat_glitch = 1, word still decodes to its intended value.
- Partial frame: 10 bits then 200 low cycles -> stat_frame_err = 1, no tvalid. The next full word 0x12345678 decodes correctly.
- Stuck high: line held high 500 cycles with max_high = 100 -> stat_frame_err = 1. After 120 low cycles the next word decodes.
- Async reset mid-word: assert aresetn low at bit 17 -> outputs 0 immediately. After release and re-arm, a fresh word decodes with no residue from the old bits.

Source files
------------

// File: rtl/pw_bit_pkg.sv
// ----------------------------------------------------------------------------
// pw_bit_pkg
// Shared definitions for the pulse-width bit link: receiver FSM state type and
// the default timing constants used by both the transmitter and receiver.
// ----------------------------------------------------------------------------
package pw_bit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for the line to be quiet long enough to arm
        HIGH  = 2'd1,   // measuring a high pulse
        LOW   = 2'd2,   // measuring the gap after a pulse
        STUCK = 2'd3    // line held high too long; wait for a quiet line
    } rx_state_t;

    // Default timing in clock cycles.
    localparam int T0_HIGH        = 15;
    localparam int T1_HIGH        = 30;
    localparam int BIT_PERIOD     = 60;
    localparam int DEFAULT_THRESH = 23;
    localparam int DEFAULT_IDLE   = 120;

endpackage

// File: rtl/pw_bit_sync.sv
// ----------------------------------------------------------------------------
// pw_bit_sync
// Multi-flop synchroniser for the asynchronous rxd line plus edge detector.
//
// Ports:
//   aclk, aresetn  clock / asynchronous active-low reset
//   rxd            asynchronous input line
//   rxd_s          synchronised line
//   rise, fall     single-cycle edge strobes derived from rxd_s
// ----------------------------------------------------------------------------
module pw_bit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic rxd,
    output logic rxd_s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxd_d_reg;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_reg  <= '0;
            rxd_d_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], rxd};
            rxd_d_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rxd_s = sync_reg[SYNC_STAGES-1];
    assign rise  = rxd_s & ~rxd_d_reg;
    assign fall  = ~rxd_s & rxd_d_reg;

endmodule

// File: rtl/pw_bit_rx.sv
// ----------------------------------------------------------------------------
// pw_bit_rx
// Single-lane pulse-width bit decoder. A long high pulse is a 1, a short one a
// 0; bits are shifted MSB first into a DATA_WIDTH word which is handed to a
// single-entry AXI-Stream style output register.
//
// Ports:
//   aclk, aresetn                  clock / asynchronous active-low reset
//   rxd                            asynchronous pulse-width line
//   cfg_enable                     0 forces IDLE, disarms and drops the partial word
//   cfg_min_high                   pulses shorter than this are glitches
//   cfg_thresh                     high count >= thresh decodes as 1
//   cfg_max_high                   high count above this is a stuck line
//   cfg_idle                       low count that ends a frame / arms the decoder
//   m_axis_tdata/tvalid/tready     decoded word stream
//   stat_frame_err/glitch/overflow sticky status flags
//   stat_clear                     single-cycle clear of all status flags
// ----------------------------------------------------------------------------
module pw_bit_rx
    import pw_bit_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  rxd,
    input  logic                  cfg_enable,
    input  logic [CNT_WIDTH-1:0]  cfg_min_high,
    input  logic [CNT_WIDTH-1:0]  cfg_thresh,
    input  logic [CNT_WIDTH-1:0]  cfg_max_high,
    input  logic [CNT_WIDTH-1:0]  cfg_idle,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  stat_frame_err,
    output logic                  stat_glitch,
    output logic                  stat_overflow,
    input  logic                  stat_clear
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic rxd_s;
    logic rise;
    logic fall;

    pw_bit_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .rxd     (rxd),
        .rxd_s   (rxd_s),
        .rise    (rise),
        .fall    (fall)
    );

    rx_state_t             state_reg;
    logic                  armed_reg;
    logic [CNT_WIDTH-1:0]  high_cnt_reg;
    logic [CNT_WIDTH-1:0]  low_cnt_reg;
    logic [BW-1:0]         bit_cnt_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  done_reg;
    logic                  frame_err_reg;
    logic                  glitch_reg;
    logic [DATA_WIDTH-1:0] tdata_reg;
    logic                  tvalid_reg;
    logic                  overflow_reg;

    logic [CNT_WIDTH-1:0]  low_inc;
    logic                  idle_hit;
    logic                  bit_val;
    logic [DATA_WIDTH-1:0] shift_next;

    assign low_inc    = sat_inc(low_cnt_reg);
    assign idle_hit   = (low_inc >= cfg_idle);
    assign bit_val    = (high_cnt_reg >= cfg_thresh);
    assign shift_next = (shift_reg << 1) | DATA_WIDTH'(bit_val);

    // Decoder FSM. Status clears are written first so that a set event later
    // in the same cycle takes precedence.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= IDLE;
            armed_reg     <= 1'b0;
            high_cnt_reg  <= '0;
            low_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            done_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            glitch_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (stat_clear) begin
                frame_err_reg <= 1'b0;
                glitch_reg    <= 1'b0;
            end
            if (!cfg_enable) begin
                state_reg    <= IDLE;
                armed_reg    <= 1'b0;
                high_cnt_reg <= '0;
                low_cnt_reg  <= '0;
                bit_cnt_reg  <= '0;
                shift_reg    <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        // Only a rise after a full quiet period starts decoding,
                        // so we never lock on in the middle of a frame.
                        if (armed_reg && rise) begin
                            state_reg    <= HIGH;
                            high_cnt_reg <= CNT_WIDTH'(1);
                            low_cnt_reg  <= '0;
                        end else if (rxd_s) begin
                            low_cnt_reg <= '0;
                        end else begin
                            low_cnt_reg <= low_inc;
                            if (idle_hit) begin
                                armed_reg <= 1'b1;
                            end
                        end
                    end
                    HIGH: begin
                        // The stuck test comes first so a pulse one cycle over
                        // the limit is rejected even if it ends this cycle.
                        if (high_cnt_reg > cfg_max_high) begin
                            frame_err_reg <= 1'b1;
                            bit_cnt_reg   <= '0;
                            shift_reg     <= '0;
                            low_cnt_reg   <= '0;
                            state_reg     <= STUCK;
                        end else if (fall) begin
                            low_cnt_reg <= '0;
                            state_reg   <= LOW;
                            if (high_cnt_reg < cfg_min_high) begin
                                glitch_reg <= 1'b1;
                            end else begin
                                shift_reg <= shift_next;
                                if (bit_cnt_reg == BIT_LAST) begin
                                    bit_cnt_reg <= '0;
                                    done_reg    <= 1'b1;
                                end else begin
                                    bit_cnt_reg <= bit_cnt_reg + BW'(1);
                                end
                            end
                        end else begin
                            high_cnt_reg <= sat_inc(high_cnt_reg);
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            state_reg    <= HIGH;
                            high_cnt_reg <= CNT_WIDTH'(1);
                            low_cnt_reg  <= '0;
                        end else begin
                            low_cnt_reg <= low_inc;
                            if (idle_hit) begin
                                // A completed word stays in shift_reg untouched
                                // so the output stage can still pick it up.
                                if (bit_cnt_reg != '0) begin
                                    frame_err_reg <= 1'b1;
                                    bit_cnt_reg   <= '0;
                                    shift_reg     <= '0;
                                end
                                armed_reg <= 1'b1;
                                state_reg <= IDLE;
                            end
                        end
                    end
                    STUCK: begin
                        if (rxd_s) begin
                            low_cnt_reg <= '0;
                        end else begin
                            low_cnt_reg <= low_inc;
                            if (idle_hit) begin
                                armed_reg <= 1'b1;
                                state_reg <= IDLE;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    // Single-entry output register, loaded the cycle after the completing shift.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tdata_reg    <= '0;
            tvalid_reg   <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            if (stat_clear) begin
                overflow_reg <= 1'b0;
            end
            if (done_reg) begin
                if (tvalid_reg && !m_axis_tready) begin
                    overflow_reg <= 1'b1;
                end else begin
                    tdata_reg  <= shift_reg;
                    tvalid_reg <= 1'b1;
                end
            end else if (tvalid_reg && m_axis_tready) begin
                tvalid_reg <= 1'b0;
            end
        end
    end

    assign m_axis_tdata   = tdata_reg;
    assign m_axis_tvalid  = tvalid_reg;
    assign stat_frame_err = frame_err_reg;
    assign stat_glitch    = glitch_reg;
    assign stat_overflow  = overflow_reg;

endmodule

// File: tb/tb_pw_bit_rx.sv
// ----------------------------------------------------------------------------
// tb_pw_bit_rx
// Self-checking bench for pw_bit_rx: directed corner sequences, a table of
// timing vectors, and random pulse trains classified by a pulse-width model.
// ----------------------------------------------------------------------------
module tb_pw_bit_rx;
    import pw_bit_pkg::*;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int SS = 2;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          rxd = 1'b0;
    logic          cfg_enable = 1'b0;
    logic [CW-1:0] cfg_min_high;
    logic [CW-1:0] cfg_thresh;
    logic [CW-1:0] cfg_max_high;
    logic [CW-1:0] cfg_idle;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          stat_frame_err;
    logic          stat_glitch;
    logic          stat_overflow;
    logic          stat_clear = 1'b0;

    always #5 aclk = ~aclk;

    pw_bit_rx #(
        .DATA_WIDTH  (DW),
        .CNT_WIDTH   (CW),
        .SYNC_STAGES (SS)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .rxd            (rxd),
        .cfg_enable     (cfg_enable),
        .cfg_min_high   (cfg_min_high),
        .cfg_thresh     (cfg_thresh),
        .cfg_max_high   (cfg_max_high),
        .cfg_idle       (cfg_idle),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .stat_frame_err (stat_frame_err),
        .stat_glitch    (stat_glitch),
        .stat_overflow  (stat_overflow),
        .stat_clear     (stat_clear)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] acc_q[$];

    // Inputs change 1 unit after posedge, so the negedge sees settled values.
    always @(negedge aclk) begin
        if (m_axis_tvalid && m_axis_tready) begin
            acc_q.push_back(m_axis_tdata);
            $display("[%0t] word accepted 0x%08h", $time, m_axis_tdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] acc_at(input int i);
        if (i < acc_q.size()) return acc_q[i];
        return 'x;
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) tick();
    endtask

    task automatic clear_stats();
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
    endtask

    // Sends bits n-1..0 of w, MSB first.
    task automatic send_bits(input logic [63:0] w, input int n, input int t0,
                             input int t1, input int period);
        for (int i = n - 1; i >= 0; i--) begin
            int hi;
            hi = w[i] ? t1 : t0;
            hold(1'b1, hi);
            hold(1'b0, period - hi);
        end
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        send_bits(64'(w), DW, T0_HIGH, T1_HIGH, BIT_PERIOD);
    endtask

    // Reference pulse classification: 2 = glitch, otherwise the decoded bit.
    function automatic int classify(input int width);
        if (width < int'(cfg_min_high)) return 2;
        if (width >= int'(cfg_thresh)) return 1;
        return 0;
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        int            t0;
        int            t1;
        int            period;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [DW-1:0] w;
        int lat;

        vecs[0] = '{32'hA5A5A5A5, 15, 30,  60, 32'hA5A5A5A5};
        vecs[1] = '{32'h12345678, 22, 23,  60, 32'h12345678};
        vecs[2] = '{32'h0F0F3C3C,  5, 100, 110, 32'h0F0F3C3C};
        vecs[3] = '{32'hDEADBEEF, 25, 25,  50, 32'hFFFFFFFF};
        vecs[4] = '{32'hDEADBEEF, 15, 15,  40, 32'h00000000};
        vecs[5] = '{32'hC3C3C3C3, 15, 30,  31, 32'hC3C3C3C3};

        cfg_min_high  = 5;
        cfg_thresh    = CW'(DEFAULT_THRESH);
        cfg_max_high  = 100;
        cfg_idle      = CW'(DEFAULT_IDLE);
        cfg_enable    = 1'b1;
        m_axis_tready = 1'b1;

        // Reset state
        aresetn = 1'b0;
        repeat (3) tick();
        check("reset_tvalid", m_axis_tvalid, 0);
        check("reset_tdata", m_axis_tdata, 0);
        check("reset_stats", {stat_frame_err, stat_glitch, stat_overflow}, 0);
        aresetn = 1'b1;

        // Arm, send one word, measure latency of the final falling edge
        hold(1'b0, 130);
        acc_q.delete();
        w = 32'hA5A5A5A5;
        send_bits(64'(w >> 1), DW - 1, T0_HIGH, T1_HIGH, BIT_PERIOD);
        hold(1'b1, T1_HIGH);
        rxd = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (m_axis_tvalid && lat == 0) lat = k;
        end
        check("latency_edges", lat, SS + 2);
        hold(1'b0, 60);
        check("basic_count", acc_q.size(), 1);
        check("basic_data", acc_at(0), 32'hA5A5A5A5);
        check("basic_stats", {stat_frame_err, stat_glitch, stat_overflow}, 0);

        // Back-pressure and overflow
        m_axis_tready = 1'b0;
        acc_q.delete();
        send_word(32'h00000001);
        send_word(32'hFFFFFFFF);
        hold(1'b0, 20);
        check("bp_tvalid_held", m_axis_tvalid, 1);
        check("bp_tdata_held", m_axis_tdata, 32'h00000001);
        check("bp_overflow", stat_overflow, 1);
        m_axis_tready = 1'b1;
        repeat (5) tick();
        check("bp_accept_count", acc_q.size(), 1);
        check("bp_accept_data", acc_at(0), 32'h00000001);
        check("bp_tvalid_after", m_axis_tvalid, 0);
        clear_stats();
        check("stat_clear_overflow", stat_overflow, 0);

        // Glitch between bits
        acc_q.delete();
        w = 32'hCAFEF00D;
        send_bits(64'(w >> 16), 16, T0_HIGH, T1_HIGH, BIT_PERIOD);
        hold(1'b1, 2);
        hold(1'b0, 20);
        send_bits(64'(w), 16, T0_HIGH, T1_HIGH, BIT_PERIOD);
        hold(1'b0, 20);
        check("glitch_flag", stat_glitch, 1);
        check("glitch_frame_err", stat_frame_err, 0);
        check("glitch_count", acc_q.size(), 1);
        check("glitch_data", acc_at(0), 32'hCAFEF00D);

        // Partial frame
        clear_stats();
        acc_q.delete();
        send_bits(64'h3FF, 10, T0_HIGH, T1_HIGH, BIT_PERIOD);
        hold(1'b0, 200);
        check("partial_frame_err", stat_frame_err, 1);
        check("partial_no_word", acc_q.size(), 0);
        clear_stats();
        send_word(32'h12345678);
        hold(1'b0, 20);
        check("partial_next_count", acc_q.size(), 1);
        check("partial_next_data", acc_at(0), 32'h12345678);

        // Stuck high mid-word
        clear_stats();
        acc_q.delete();
        send_bits(64'h15, 5, T0_HIGH, T1_HIGH, BIT_PERIOD);
        hold(1'b1, 500);
        check("stuck_frame_err", stat_frame_err, 1);
        hold(1'b0, 125);
        clear_stats();
        send_word(32'h13579BDF);
        hold(1'b0, 20);
        check("stuck_next_count", acc_q.size(), 1);
        check("stuck_next_data", acc_at(0), 32'h13579BDF);
        check("stuck_next_stats", {stat_frame_err, stat_glitch, stat_overflow}, 0);

        // Asynchronous reset mid-word with a word held and flags set
        m_axis_tready = 1'b0;
        send_word(32'h55555555);
        hold(1'b1, 2);
        hold(1'b0, 20);
        send_bits(64'hDEADBEEF >> 15, 17, T0_HIGH, T1_HIGH, BIT_PERIOD);
        rxd = 1'b1;
        repeat (7) tick();
        check("pre_reset_tvalid", m_axis_tvalid, 1);
        check("pre_reset_glitch", stat_glitch, 1);
        #2;
        aresetn = 1'b0;
        #1;
        check("async_reset_tvalid", m_axis_tvalid, 0);
        check("async_reset_tdata", m_axis_tdata, 0);
        check("async_reset_stats", {stat_frame_err, stat_glitch, stat_overflow}, 0);
        tick();
        rxd = 1'b0;
        tick();
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        acc_q.delete();
        hold(1'b0, 130);
        send_word(32'h0F0F0F0F);
        hold(1'b0, 20);
        check("post_reset_count", acc_q.size(), 1);
        check("post_reset_data", acc_at(0), 32'h0F0F0F0F);

        // Enable drop mid-word: disarms, flags untouched, must re-arm
        clear_stats();
        hold(1'b1, 2);
        hold(1'b0, 20);
        acc_q.delete();
        send_bits(64'hFF, 8, T0_HIGH, T1_HIGH, BIT_PERIOD);
        cfg_enable = 1'b0;
        repeat (2) tick();
        cfg_enable = 1'b1;
        check("enable_glitch_kept", stat_glitch, 1);
        send_word(32'h89ABCDEF);
        hold(1'b0, 130);
        check("enable_unarmed_no_word", acc_q.size(), 0);
        check("enable_unarmed_no_err", stat_frame_err, 0);
        send_word(32'h89ABCDEF);
        hold(1'b0, 20);
        check("enable_rearm_count", acc_q.size(), 1);
        check("enable_rearm_data", acc_at(0), 32'h89ABCDEF);

        // Table of timing vectors
        for (int v = 0; v < 6; v++) begin
            clear_stats();
            acc_q.delete();
            send_bits(64'(vecs[v].data), DW, vecs[v].t0, vecs[v].t1, vecs[v].period);
            hold(1'b0, 20);
            check($sformatf("vec%0d_count", v), acc_q.size(), 1);
            check($sformatf("vec%0d_data", v), acc_at(0), vecs[v].exp_data);
            check($sformatf("vec%0d_stats", v), {stat_frame_err, stat_glitch}, 0);
        end

        // Random pulse trains against the classification model
        for (int r = 0; r < 6; r++) begin
            logic [DW-1:0] exp_w;
            logic          exp_gl;
            int            nb;
            int            guard;
            exp_w  = '0;
            exp_gl = 1'b0;
            nb     = 0;
            guard  = 0;
            clear_stats();
            acc_q.delete();
            while (nb < DW && guard < 400) begin
                int width;
                int kind;
                width = $urandom_range(1, 60);
                hold(1'b1, width);
                hold(1'b0, $urandom_range(1, 40));
                kind = classify(width);
                if (kind == 2) begin
                    exp_gl = 1'b1;
                end else begin
                    exp_w = {exp_w[DW-2:0], kind[0]};
                    nb++;
                end
                guard++;
            end
            hold(1'b0, 20);
            check($sformatf("rand%0d_count", r), acc_q.size(), 1);
            check($sformatf("rand%0d_data", r), acc_at(0), exp_w);
            check($sformatf("rand%0d_glitch", r), stat_glitch, exp_gl);
            check($sformatf("rand%0d_frame_err", r), stat_frame_err, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
